fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage. It owns the program counter, issues requests to a variable-latency instruction memory, and drives the IF/ID pipeline register (instruction, PC+2, valid) that decode consumes. It honours decode's `stall` and `doBranch`: it holds on a stall, and on a branch it redirects the PC and flushes the IF/ID register to a NOP bubble. It stops fetching after a HALT enters IF/ID.

## Interface
- No parameters. Data width is fixed at 16 bits. NOP bubble = 16'h0800. HALT opcode = instr[15:11] == 5'b00000.
- `clk`  in  1  — the single clock for the block.
- `rst`  in  1  — asynchronous, active-high reset.
- `stall`  in  1  — hazard hold from decode. IF/ID holds while high.
- `doBranch`  in  1  — redirect request. Flushes IF/ID and loads the PC from `branchTarget`.
- `branchTarget`  in  16  — redirect address, sampled only when `doBranch`=1.
- `imemReq`  out  1  — fetch request to instruction memory.
- `imemAddr`  out  16  — fetch address. Stable while `imemReq`=1 and `imemDone`=0.
- `imemData`  in  16  — instruction word, valid only when `imemDone`=1.
- `imemDone`  in  1  — request complete. May assert in the same cycle as `imemReq` (zero-wait hit) or any later cycle.
- `instrOut`  out  16  — IF/ID instruction (feeds decode `instrIn`).
- `nextPcOut`  out  16  — IF/ID PC+2 of `instrOut`.
- `validOut`  out  1  — IF/ID holds a real instruction (0 = bubble).
- `fetchHalted`  out  1  — a HALT has been fetched and fetching has stopped.
- `err`  out  1  — sticky flag: a misaligned branch target was seen.

## Operation
- **State:** `pc`[15:0], `state` ∈ {RUN, SQUASH, HALTED}, `redirPc`[15:0], skid buffer (`skidInstr`, `skidPc2`, `skidValid`), IF/ID registers, `err`.
- **Outputs driven from state:** `imemAddr` = `pc`.
  - `imemReq` = 1 in SQUASH.
  - In RUN, `imemReq` = ~`skidValid` & (~`stall` | request outstanding).
  - `imemReq` = 0 in HALTED.
- **"Outstanding" flag:** set when `imemReq`=1 and `imemDone`=0; cleared on `imemDone`. The address and request must not drop while the flag is set, even under `stall`.
- **RUN, `imemDone`=1, no `doBranch`, no `stall`:**
  - IF/ID ← {`imemData`, `pc`+2, 1}.
  - `pc` ← `pc`+2.
- **RUN, `imemDone`=1, `stall`=1:**
  - Word goes to the skid buffer ({`imemData`, `pc`+2}, `skidValid`=1) and `pc` ← `pc`+2.
  - IF/ID holds.
- **Skid drain:** in the first cycle with `stall`=0, IF/ID ← skid and `skidValid` ← 0. No new request is issued in that cycle.
- **`stall`=1 with nothing returning:** IF/ID, `pc` and skid all hold.
- **`doBranch`=1 (has priority over `stall`, skid and halt):**
  - IF/ID ← {16'h0800, 16'h0000, 0}.
  - `skidValid` ← 0.
  - If a request is outstanding and `imemDone`=0: `redirPc` ← target and `state` ← SQUASH.
  - Otherwise (including `imemDone`=1 in the same cycle): `pc` ← target, `state` ← RUN, and any returning word is discarded.
- **SQUASH:**
  - Hold `imemAddr`/`imemReq` until `imemDone`.
  - On `imemDone`: discard `imemData`, `pc` ← `redirPc`, `state` ← RUN.
  - A further `doBranch` while in SQUASH overwrites `redirPc`.
- **Halt:**
  - When a word with opcode 5'b00000 loads into IF/ID (direct or from skid), `state` ← HALTED and `fetchHalted`=1.
  - `pc` stops advancing.
  - IF/ID keeps the HALT until `stall` drops, then loads a bubble.
  - `doBranch` in HALTED resumes RUN at the target and clears `fetchHalted`.
- **Alignment:** if `branchTarget`[0]=1 on `doBranch`, `err` ← 1 (sticky until `rst`) and the target used is {`branchTarget`[15:1], 1'b0}.
- **Arithmetic:** PC+2 is modulo 2^16; 16'hFFFE + 2 wraps to 16'h0000 with no error.

## Timing
- **Reset values (asynchronous):** `pc`=0, `state`=RUN, `instrOut`=16'h0800, `nextPcOut`=0, `validOut`=0, `skidValid`=0, `fetchHalted`=0, `err`=0, `imemReq`=0 while `rst`=1.
- **First request:** `imemReq`=1 with `imemAddr`=0 in the first cycle after `rst` falls.
- **Latency:** with zero-wait memory, a word requested in cycle N appears on `instrOut` in cycle N+1. Throughput is 1 instruction/cycle.
- **Branch:** `doBranch` in cycle N → `validOut`=0 in N+1.
  - `imemAddr`=target in N+1 if no request is outstanding.
  - If a request is outstanding, `imemAddr`=target in the cycle after the squashed `imemDone`.
- **Stall:** `stall` seen in cycle N → IF/ID unchanged at the edge ending N. Release in cycle M → IF/ID advances at the edge ending M.
- **Reset mid-operation:** returns immediately to reset values. Any memory response arriving after `rst` falls, for a pre-reset request, is the memory's responsibility and is not tracked here.

## Test plan
- **Reset, zero-wait memory:** `mem[a]`=16'h4000+a for 4 cycles → `instrOut` 16'h4000, 4002, 4004, 4006 with `nextPcOut` 2, 4, 6, 8 and `validOut`=1 each cycle.
- **3-cycle-latency memory:** `imemAddr` holds 0 for 3 cycles; `instrOut`=`mem[0]` and `nextPcOut`=2 one cycle after `imemDone`. `validOut`=0 while waiting.
- **`stall`=1 for 2 cycles while a word returns:** word lands in skid; IF/ID holds the previous instruction; no new request is issued. After release: skid word appears, then fetch resumes at the next PC.
- **`doBranch` to 16'h0100 while a 3-cycle request to 16'h0008 is outstanding:** bubble 16'h0800/`validOut`=0; returning word discarded; next `imemAddr`=16'h0100.
- **Fetch 16'h0000 (HALT) at PC 6:** `fetchHalted`=1, `imemReq`=0 thereafter. A later `doBranch` to 16'h0020 → fetch resumes at 16'h0020 and `fetchHalted`=0.
- **`doBranch` with target 16'h0031:** `err`=1 and stays 1; next `imemAddr`=16'h0030. Separately, `pc`=16'hFFFE yields `nextPcOut`=16'h0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory and drives the IF/ID register consumed by decode.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        doBranch,
    input  logic [15:0] branchTarget,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    output logic [15:0] instrOut,
    output logic [15:0] nextPcOut,
    output logic        validOut,
    output logic        fetchHalted,
    output logic        err
);
    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_redir_pc;
    logic        r_outst;
    logic [15:0] r_skid_instr_p0;
    logic [15:0] r_skid_pc2_p0;
    logic        r_skid_vld_p0;
    logic [15:0] r_instr_p1;
    logic [15:0] r_pc2_p1;
    logic        r_vld_p1;
    logic        r_halted;
    logic        r_err;

    logic        w_req;
    logic        w_ret;
    logic        w_pend;
    logic [15:0] w_pc2;
    logic [15:0] w_target;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == 5'b00000;
    endfunction

    always_comb begin
        w_req = 1'b0;
        case (r_state)
            RUN:     w_req = ~r_skid_vld_p0 & (~stall | r_outst);
            SQUASH:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    assign imemReq  = w_req & ~rst;
    assign imemAddr = r_pc;
    assign w_ret    = imemReq & imemDone;
    assign w_pend   = imemReq & ~imemDone;
    assign w_pc2    = r_pc + 16'd2;
    assign w_target = {branchTarget[15:1], 1'b0};

    assign instrOut    = r_instr_p1;
    assign nextPcOut   = r_pc2_p1;
    assign validOut    = r_vld_p1;
    assign fetchHalted = r_halted;
    assign err         = r_err;

    // skid data: captured when a word returns while decode is stalled
    always_ff @(posedge clk) begin
        if (r_state == RUN && !doBranch && w_ret && stall) begin
            r_skid_instr_p0 <= imemData;
            r_skid_pc2_p0   <= w_pc2;
        end
    end

    // IF/ID boundary and fetch control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= 16'h0000;
            r_redir_pc    <= 16'h0000;
            r_outst       <= 1'b0;
            r_skid_vld_p0 <= 1'b0;
            r_instr_p1    <= NOP;
            r_pc2_p1      <= 16'h0000;
            r_vld_p1      <= 1'b0;
            r_halted      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_outst <= w_pend;
            if (doBranch) begin
                r_instr_p1    <= NOP;
                r_pc2_p1      <= 16'h0000;
                r_vld_p1      <= 1'b0;
                r_skid_vld_p0 <= 1'b0;
                r_halted      <= 1'b0;
                if (branchTarget[0])
                    r_err <= 1'b1;
                // an in-flight word must still be absorbed before redirecting
                if (w_pend) begin
                    r_redir_pc <= w_target;
                    r_state    <= SQUASH;
                end else begin
                    r_pc    <= w_target;
                    r_state <= RUN;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        if (r_skid_vld_p0) begin
                            if (!stall) begin
                                r_instr_p1    <= r_skid_instr_p0;
                                r_pc2_p1      <= r_skid_pc2_p0;
                                r_vld_p1      <= 1'b1;
                                r_skid_vld_p0 <= 1'b0;
                                if (is_halt(r_skid_instr_p0)) begin
                                    r_state  <= HALTED;
                                    r_halted <= 1'b1;
                                end
                            end
                        end else if (w_ret) begin
                            r_pc <= w_pc2;
                            if (stall) begin
                                r_skid_vld_p0 <= 1'b1;
                            end else begin
                                r_instr_p1 <= imemData;
                                r_pc2_p1   <= w_pc2;
                                r_vld_p1   <= 1'b1;
                                if (is_halt(imemData)) begin
                                    r_state  <= HALTED;
                                    r_halted <= 1'b1;
                                end
                            end
                        end else if (!stall) begin
                            r_instr_p1 <= NOP;
                            r_pc2_p1   <= 16'h0000;
                            r_vld_p1   <= 1'b0;
                        end
                    end
                    SQUASH: begin
                        if (w_ret) begin
                            r_pc    <= r_redir_pc;
                            r_state <= RUN;
                        end
                    end
                    default: begin
                        if (!stall) begin
                            r_instr_p1 <= NOP;
                            r_pc2_p1   <= 16'h0000;
                            r_vld_p1   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stall/branch/latency traffic against a transaction-level model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        doBranch;
    logic [15:0] branchTarget;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemDone;
    logic [15:0] instrOut;
    logic [15:0] nextPcOut;
    logic        validOut;
    logic        fetchHalted;
    logic        err;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .doBranch(doBranch),
        .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemData(imemData), .imemDone(imemDone), .instrOut(instrOut),
        .nextPcOut(nextPcOut), .validOut(validOut), .fetchHalted(fetchHalted),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // memory behaviour
    logic [15:0] halt_addr;
    bit          rand_halts;
    int          lat_fix;
    bit          mem_active;
    int          mem_cnt;
    int          mem_lat;

    // reference model
    logic [15:0] m_pc, m_instr, m_pc2, m_redir;
    bit          m_vld, m_halted, m_err, m_sq, m_inflight;
    logic [31:0] m_skid[$];

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (a == halt_addr) return 16'h0000;
        if (rand_halts && a[5:1] == 5'h1F) return {5'b00000, a[10:0]};
        return a[15] ? a : 16'h4000 + a;
    endfunction

    function automatic bit op_halt(input logic [15:0] w);
        return w[15:11] == 5'd0;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0; m_instr = 16'h0800; m_pc2 = 16'h0; m_redir = 16'h0;
        m_vld = 0; m_halted = 0; m_err = 0; m_sq = 0; m_inflight = 0;
        m_skid.delete();
    endtask

    task automatic m_load(input logic [15:0] w, input logic [15:0] p2);
        m_instr = w; m_pc2 = p2; m_vld = 1;
        if (op_halt(w)) m_halted = 1;
    endtask

    task automatic m_bubble();
        m_instr = 16'h0800; m_pc2 = 16'h0; m_vld = 0;
    endtask

    // One clock cycle: apply inputs, answer from memory, compare, advance model.
    task automatic cycle(input bit st, input bit br, input logic [15:0] tg);
        bit          exp_req, ret, pend;
        logic [31:0] e;
        stall = st; doBranch = br; branchTarget = tg;
        #1;
        if (imemReq) begin
            if (!mem_active) begin
                mem_active = 1; mem_cnt = 0;
                mem_lat = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
            end
            imemDone = (mem_cnt == mem_lat);
            imemData = memword(imemAddr);
        end else begin
            imemDone = 1'b0;
            imemData = 16'($urandom);
        end
        #1;
        exp_req = m_sq || (!m_halted && m_skid.size() == 0 && (!st || m_inflight));
        chk("imemReq",     16'(imemReq),     16'(exp_req));
        chk("imemAddr",    imemAddr,         m_pc);
        chk("instrOut",    instrOut,         m_instr);
        chk("nextPcOut",   nextPcOut,        m_pc2);
        chk("validOut",    16'(validOut),    16'(m_vld));
        chk("fetchHalted", 16'(fetchHalted), 16'(m_halted));
        chk("err",         16'(err),         16'(m_err));
        ret  = exp_req && imemDone;
        pend = exp_req && !imemDone;
        if (br) begin
            if (tg[0]) m_err = 1;
            m_bubble();
            m_skid.delete();
            m_halted = 0;
            if (pend) begin m_sq = 1; m_redir = tg & 16'hFFFE; end
            else begin m_sq = 0; m_pc = tg & 16'hFFFE; end
        end else if (m_sq) begin
            if (ret) begin m_pc = m_redir; m_sq = 0; end
        end else if (m_halted) begin
            if (!st) m_bubble();
        end else if (m_skid.size() != 0) begin
            if (!st) begin e = m_skid.pop_front(); m_load(e[31:16], e[15:0]); end
        end else if (ret) begin
            e = {memword(m_pc), 16'(m_pc + 16'd2)};
            m_pc = m_pc + 16'd2;
            if (st) m_skid.push_back(e);
            else m_load(e[31:16], e[15:0]);
        end else if (!st) begin
            m_bubble();
        end
        m_inflight = pend;
        if (imemReq && mem_active) begin
            if (imemDone) mem_active = 0;
            else mem_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 0; doBranch = 0; branchTarget = 16'h0;
        imemDone = 0; imemData = 16'h0;
        @(negedge clk);
        chk("rst_imemReq",     16'(imemReq),     16'h0);
        chk("rst_instrOut",    instrOut,         16'h0800);
        chk("rst_nextPcOut",   nextPcOut,        16'h0);
        chk("rst_validOut",    16'(validOut),    16'h0);
        chk("rst_fetchHalted", 16'(fetchHalted), 16'h0);
        chk("rst_err",         16'(err),         16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mem_active = 0;
    endtask

    initial begin
        bit          st, br;
        logic [15:0] tg;
        halt_addr = 16'h0001; rand_halts = 0; lat_fix = 0;

        // zero-wait stream after reset
        do_reset();
        stall = 0; #1;
        chk("first_req",  16'(imemReq), 16'h1);
        chk("first_addr", imemAddr,     16'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 0, 16'h0);
            chk("zw_instr", instrOut,      16'h4000 + 16'(2 * (k - 1)));
            chk("zw_pc2",   nextPcOut,     16'(2 * k));
            chk("zw_vld",   16'(validOut), 16'h1);
        end

        // three-cycle memory
        lat_fix = 2;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 16'h0);
            chk("lat_vld",  16'(validOut), 16'h0);
            chk("lat_addr", imemAddr,      16'h0);
        end
        cycle(0, 0, 16'h0);
        chk("lat_instr", instrOut,  16'h4000);
        chk("lat_pc2",   nextPcOut, 16'h0002);

        // word returns into skid under stall
        lat_fix = 1;
        do_reset();
        cycle(0, 0, 16'h0);
        cycle(1, 0, 16'h0);
        chk("skid_vld_hold", 16'(validOut), 16'h0);
        stall = 1; #1;
        chk("skid_noreq_stall", 16'(imemReq), 16'h0);
        cycle(1, 0, 16'h0);
        stall = 0; #1;
        chk("skid_noreq_drain", 16'(imemReq), 16'h0);
        cycle(0, 0, 16'h0);
        chk("skid_instr", instrOut,  16'h4000);
        chk("skid_pc2",   nextPcOut, 16'h0002);
        chk("skid_next",  imemAddr,  16'h0002);

        // branch while a request is in flight
        lat_fix = 0;
        do_reset();
        for (int k = 0; k < 4; k++) cycle(0, 0, 16'h0);
        lat_fix = 2;
        cycle(0, 0, 16'h0);
        cycle(0, 1, 16'h0100);
        chk("sq_instr", instrOut,      16'h0800);
        chk("sq_vld",   16'(validOut), 16'h0);
        lat_fix = 0;
        cycle(0, 0, 16'h0);
        chk("sq_addr",  imemAddr,      16'h0100);
        chk("sq_vld2",  16'(validOut), 16'h0);
        cycle(0, 0, 16'h0);
        chk("sq_first", instrOut,      16'h4100);

        // HALT at PC 6, resume by branch
        halt_addr = 16'h0006;
        do_reset();
        for (int k = 0; k < 4; k++) cycle(0, 0, 16'h0);
        chk("halt_instr", instrOut,         16'h0000);
        chk("halt_flag",  16'(fetchHalted), 16'h1);
        stall = 0; #1;
        chk("halt_noreq", 16'(imemReq),     16'h0);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        cycle(0, 1, 16'h0020);
        chk("resume_flag", 16'(fetchHalted), 16'h0);
        chk("resume_addr", imemAddr,         16'h0020);
        cycle(0, 0, 16'h0);
        chk("resume_instr", instrOut,  16'h4020);
        chk("resume_pc2",   nextPcOut, 16'h0022);

        // misaligned target, then PC wrap
        cycle(0, 1, 16'h0031);
        chk("mis_err",  16'(err), 16'h1);
        chk("mis_addr", imemAddr, 16'h0030);
        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0);
        chk("mis_sticky", 16'(err), 16'h1);
        cycle(0, 1, 16'hFFFE);
        cycle(0, 0, 16'h0);
        chk("wrap_instr", instrOut,  16'hFFFE);
        chk("wrap_pc2",   nextPcOut, 16'h0000);
        chk("wrap_addr",  imemAddr,  16'h0000);

        // randomized traffic
        halt_addr = 16'h0001; rand_halts = 1; lat_fix = -1;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 800; i++) begin
                st = ($urandom_range(0, 3) == 0);
                br = ($urandom_range(0, 15) == 0);
                tg = 16'($urandom);
                if ($urandom_range(0, 1) == 1) tg = {8'h00, tg[7:0]};
                cycle(st, br, tg);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
